data_mem_responder: RTL

- Memory-side responder for CPU load/store requests. Replaces the zero-latency data memory with a valid/ready request/response slave.
- Contains its own little-endian 64-bit-word storage, with byte, half, word and double access sizing and configurable wait states.
- Owns the sub-word sign/zero extension and byte-lane merging, so the datapath only issues sized requests.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size/state types and helpers for the data memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane extract/extend for loads and lane merge for stores
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_word
);

  logic [5:0]  bit_ofs;
  logic [63:0] shifted;
  logic [63:0] size_mask;

  assign bit_ofs = {lane, 3'b000};
  assign shifted = word >> bit_ofs;

  always_comb begin
    size_mask = '1;
    load_data = shifted;
    case (size_e'(size))
      SZ_B: begin
        size_mask = 64'h0000_0000_0000_00FF;
        load_data = zero_ext ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        load_data = zero_ext ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        load_data = zero_ext ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        size_mask = '1;
        load_data = shifted;
      end
    endcase
  end

  // Only the lanes covered by the access are replaced; the rest of the word is kept
  assign store_word = (word & ~(size_mask << bit_ofs)) | ((wdata & size_mask) << bit_ofs);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - valid/ready data memory slave with wait states; optional DMEM_RESP_STATS_EN counters
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] err_count
`endif
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] ADDR_LIM = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e             state, state_next;
  logic [3:0]         cnt;
  logic               wr_q, uns_q;
  logic [1:0]         size_q;
  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         lane_q;
  logic [63:0]        wdata_q;

  logic               req_err, accept, access, in_idle;
  logic               cur_write, cur_uns;
  logic [1:0]         cur_size;
  logic [IDX_W-1:0]   cur_idx;
  logic [2:0]         cur_lane;
  logic [63:0]        cur_wdata, cur_word;
  logic [63:0]        load_data, store_word;
  logic [63:0]        mem [DEPTH_WORDS];

  assign req_err = ((req_addr[2:0] & 3'(size_bytes(size_e'(req_size)) - 4'd1)) != 3'd0)
                || (req_addr >= ADDR_LIM);

  // With zero wait states the access happens in the acceptance cycle, so use the live request
  assign in_idle   = (state == IDLE);
  assign cur_write = in_idle ? req_write          : wr_q;
  assign cur_uns   = in_idle ? req_unsigned       : uns_q;
  assign cur_size  = in_idle ? req_size           : size_q;
  assign cur_idx   = in_idle ? req_addr[IDX_W+2:3] : idx_q;
  assign cur_lane  = in_idle ? req_addr[2:0]      : lane_q;
  assign cur_wdata = in_idle ? req_wdata          : wdata_q;
  assign cur_word  = mem[cur_idx];

  dmem_lane_align u_align (
    .word       (cur_word),
    .lane       (cur_lane),
    .size       (cur_size),
    .zero_ext   (cur_uns),
    .wdata      (cur_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            state_next = RESP;
          end else if (LATENCY == 0) begin
            access     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      idx_q      <= '0;
      lane_q     <= 3'd0;
      wdata_q    <= 64'd0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wr_q    <= req_write;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        idx_q   <= req_addr[IDX_W+2:3];
        lane_q  <= req_addr[2:0];
        wdata_q <= req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (accept && req_err) begin
        resp_err   <= 1'b1;
        resp_rdata <= 64'd0;
      end else if (access) begin
        resp_err   <= 1'b0;
        resp_rdata <= cur_write ? 64'd0 : load_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (access && cur_write) mem[cur_idx] <= store_word;
  end

`ifdef DMEM_RESP_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_count  <= 32'd0;
      store_count <= 32'd0;
      err_count   <= 32'd0;
    end else if (state == RESP && resp_ready) begin
      if (resp_err) begin
        if (err_count != '1) err_count <= err_count + 32'd1;
      end else if (wr_q) begin
        if (store_count != '1) store_count <= store_count + 32'd1;
      end else begin
        if (load_count != '1) load_count <= load_count + 32'd1;
      end
    end
  end
`endif

endmodule
